// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 arbiter: shares one slave port between NUM_MASTERS
// packed master ports. A grant is held for the whole cyc of the winner so bursts
// pass through intact. A per-access watchdog aborts hung accesses with err.
module wb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [AW*NUM_MASTERS-1:0]     wbm_adr_i,
  input  logic [DW*NUM_MASTERS-1:0]     wbm_dat_i,
  input  logic [(DW/8)*NUM_MASTERS-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [3*NUM_MASTERS-1:0]      wbm_cti_i,
  input  logic [2*NUM_MASTERS-1:0]      wbm_bte_i,
  output logic [DW*NUM_MASTERS-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          timeout_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Watchdog fires on the TIMEOUT-th waiting cycle, i.e. while the count is TIMEOUT-1.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusy  = 2'd1;
  localparam logic [1:0] StAbort = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic [15:0]            wdog_q, wdog_d;

  // Unpacked views of the master request vectors.
  logic [AW-1:0] adr_arr [NUM_MASTERS];
  logic [DW-1:0] dat_arr [NUM_MASTERS];
  logic [SW-1:0] sel_arr [NUM_MASTERS];
  logic [2:0]    cti_arr [NUM_MASTERS];
  logic [1:0]    bte_arr [NUM_MASTERS];

  logic          busy, g_cyc, g_stb, slv_resp, waiting, fire;
  logic          pick_valid;
  logic [LW-1:0] pick_idx;
  int            rr_cand;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_master
    assign adr_arr[k] = wbm_adr_i[AW*k +: AW];
    assign dat_arr[k] = wbm_dat_i[DW*k +: DW];
    assign sel_arr[k] = wbm_sel_i[SW*k +: SW];
    assign cti_arr[k] = wbm_cti_i[3*k +: 3];
    assign bte_arr[k] = wbm_bte_i[2*k +: 2];

    // Responses reach only the granted master, and only while BUSY.
    assign wbm_dat_o[DW*k +: DW] = (busy && grant_q[k]) ? wbs_dat_i : '0;
    assign wbm_ack_o[k] = busy && grant_q[k] && wbs_ack_i;
    assign wbm_rty_o[k] = busy && grant_q[k] && wbs_rty_i;
    assign wbm_err_o[k] = busy && grant_q[k] && (wbs_err_i || fire);
  end

  assign busy     = (state_q == StBusy);
  assign g_cyc    = wbm_cyc_i[last_q];
  assign g_stb    = wbm_stb_i[last_q];
  assign slv_resp = wbs_ack_i || wbs_err_i || wbs_rty_i;
  assign waiting  = busy && g_cyc && g_stb && !slv_resp;
  assign fire     = waiting && (wdog_q == TimeoutLast);

  assign grant_o   = grant_q;
  assign timeout_o = fire;

  // Round-robin pick: scan from the farthest candidate back so the nearest after last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    rr_cand    = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      rr_cand = int'(last_q) + k;
      if (rr_cand >= int'(NUM_MASTERS)) rr_cand = rr_cand - int'(NUM_MASTERS);
      if (wbm_cyc_i[LW'(rr_cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = LW'(rr_cand);
      end
    end
  end

  // Slave request mux: granted master's signals while BUSY, all zero otherwise.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (busy) begin
      wbs_adr_o = adr_arr[last_q];
      wbs_dat_o = dat_arr[last_q];
      wbs_sel_o = sel_arr[last_q];
      wbs_we_o  = wbm_we_i[last_q];
      wbs_cyc_o = g_cyc;
      wbs_stb_o = g_stb;
      wbs_cti_o = cti_arr[last_q];
      wbs_bte_o = bte_arr[last_q];
    end
  end

  // Watchdog counts only cycles where the granted strobe waits without any response.
  always_comb begin
    wdog_d = '0;
    if (waiting && !fire) wdog_d = wdog_q + 16'd1;
  end

  // Arbitration FSM: grant on request, hold for the whole cycle, abort on watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d           = StBusy;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_d            = pick_idx;
        end
      end
      StBusy: begin
        if (!g_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (fire) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        if (!g_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers; last resets to the top master so master 0 wins first.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, TIMEOUT=8. Inputs change 1 time
// unit after each rising edge; outputs are sampled on the falling edge.
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;

  logic [AW-1:0] m_adr [N];
  logic [2:0]    m_cti [N];
  logic [N-1:0]  m_cyc, m_stb;

  logic [AW*N-1:0]     wbm_adr_i;
  logic [DW*N-1:0]     wbm_dat_i;
  logic [(DW/8)*N-1:0] wbm_sel_i;
  logic [N-1:0]        wbm_we_i;
  logic [3*N-1:0]      wbm_cti_i;
  logic [2*N-1:0]      wbm_bte_i;
  logic [DW*N-1:0]     wbm_dat_o;
  logic [N-1:0]        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]       wbs_adr_o;
  logic [DW-1:0]       wbs_dat_o;
  logic [DW/8-1:0]     wbs_sel_o;
  logic                wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]          wbs_cti_o;
  logic [1:0]          wbs_bte_o;
  logic [DW-1:0]       s_dat;
  logic                s_ack, s_err, s_rty;
  logic [N-1:0]        grant_o;
  logic                timeout_o;

  int checks = 0;
  int errors = 0;

  assign wbm_adr_i = {m_adr[1], m_adr[0]};
  assign wbm_cti_i = {m_cti[1], m_cti[0]};
  assign wbm_dat_i = {32'h1111_1111, 32'h0000_0000};
  assign wbm_sel_i = 8'hFF;
  assign wbm_we_i  = 2'b00;
  assign wbm_bte_i = 4'b0000;

  wb_rr_arbiter #(
    .NUM_MASTERS(N),
    .AW(AW),
    .DW(DW),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbm_adr_i(wbm_adr_i),
    .wbm_dat_i(wbm_dat_i),
    .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),
    .wbm_cyc_i(m_cyc),
    .wbm_stb_i(m_stb),
    .wbm_cti_i(wbm_cti_i),
    .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o),
    .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o),
    .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o),
    .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(s_dat),
    .wbs_ack_i(s_ack),
    .wbs_err_i(s_err),
    .wbs_rty_i(s_rty),
    .grant_o  (grant_o),
    .timeout_o(timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  cyc;      // cyc and stb driven together
    logic        ack;
    logic [31:0] dat;
    logic [1:0]  e_grant;
    logic        e_scyc;
    logic [1:0]  e_ack;
    logic [31:0] e_dat0;
    logic [31:0] e_dat1;
    logic [31:0] e_adr;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to the input-drive point just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Round-robin alternation, IDLE gaps, response isolation and address mux.
    tbl[0]  = '{2'b11, 1'b1, 32'hDEADBEEF, 2'b01, 1'b1, 2'b01, 32'hDEADBEEF, 32'h0, 32'h100};
    tbl[1]  = '{2'b10, 1'b0, 32'h0,        2'b01, 1'b0, 2'b00, 32'h0, 32'h0,        32'h100};
    tbl[2]  = '{2'b11, 1'b0, 32'h0,        2'b00, 1'b0, 2'b00, 32'h0, 32'h0,        32'h0};
    tbl[3]  = '{2'b11, 1'b1, 32'h12345678, 2'b10, 1'b1, 2'b10, 32'h0, 32'h12345678, 32'h200};
    tbl[4]  = '{2'b01, 1'b0, 32'h0,        2'b10, 1'b0, 2'b00, 32'h0, 32'h0,        32'h200};
    tbl[5]  = '{2'b11, 1'b0, 32'h0,        2'b00, 1'b0, 2'b00, 32'h0, 32'h0,        32'h0};
    tbl[6]  = '{2'b11, 1'b1, 32'hA5A5A5A5, 2'b01, 1'b1, 2'b01, 32'hA5A5A5A5, 32'h0, 32'h100};
    tbl[7]  = '{2'b10, 1'b0, 32'h0,        2'b01, 1'b0, 2'b00, 32'h0, 32'h0,        32'h100};
    tbl[8]  = '{2'b10, 1'b0, 32'h0,        2'b00, 1'b0, 2'b00, 32'h0, 32'h0,        32'h0};
    tbl[9]  = '{2'b10, 1'b1, 32'h0F0F0F0F, 2'b10, 1'b1, 2'b10, 32'h0, 32'h0F0F0F0F, 32'h200};
    tbl[10] = '{2'b00, 1'b0, 32'h0,        2'b10, 1'b0, 2'b00, 32'h0, 32'h0,        32'h200};
    tbl[11] = '{2'b00, 1'b0, 32'h0,        2'b00, 1'b0, 2'b00, 32'h0, 32'h0,        32'h0};

    rst_n    = 1'b1;
    m_adr[0] = 32'h100;
    m_adr[1] = 32'h200;
    m_cti[0] = 3'b000;
    m_cti[1] = 3'b000;
    m_cyc    = 2'b11;
    m_stb    = 2'b11;
    s_dat    = '0;
    s_ack    = 1'b0;
    s_err    = 1'b0;
    s_rty    = 1'b0;
    #1 rst_n = 1'b0;

    // Reset held with both masters requesting.
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_wbs_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("rst_wbs_stb", 64'(wbs_stb_o), 64'h0);
    chk("rst_ack", 64'(wbm_ack_o), 64'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_grant", 64'(grant_o), 64'h0);

    for (int i = 0; i < 12; i++) begin
      step();
      m_cyc = tbl[i].cyc;
      m_stb = tbl[i].cyc;
      s_ack = tbl[i].ack;
      s_dat = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", i), 64'(grant_o), 64'(tbl[i].e_grant));
      chk($sformatf("tbl%0d_wbs_cyc", i), 64'(wbs_cyc_o), 64'(tbl[i].e_scyc));
      chk($sformatf("tbl%0d_ack", i), 64'(wbm_ack_o), 64'(tbl[i].e_ack));
      chk($sformatf("tbl%0d_dat0", i), 64'(wbm_dat_o[31:0]), 64'(tbl[i].e_dat0));
      chk($sformatf("tbl%0d_dat1", i), 64'(wbm_dat_o[63:32]), 64'(tbl[i].e_dat1));
      chk($sformatf("tbl%0d_adr", i), 64'(wbs_adr_o), 64'(tbl[i].e_adr));
    end
    s_dat = '0;

    // Burst hold: master 1 bursts 4 beats while master 0 waits.
    step();
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    m_cti[1] = 3'b010;
    @(negedge clk);
    chk("burst_idle", 64'(grant_o), 64'h0);
    step();
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      m_cyc[0] = 1'b1;
      m_stb[0] = 1'b1;
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      m_adr[1] = 32'h300 + 32'(4 * b);
      s_ack    = 1'b1;
      @(negedge clk);
      chk($sformatf("burst%0d_ack", b), 64'(wbm_ack_o), 64'h2);
      chk($sformatf("burst%0d_grant", b), 64'(grant_o), 64'h2);
      chk($sformatf("burst%0d_cti", b), 64'(wbs_cti_o), (b == 3) ? 64'h7 : 64'h2);
      chk($sformatf("burst%0d_adr", b), 64'(wbs_adr_o), 64'(32'h300 + 32'(4 * b)));
    end
    step();
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    m_cti[1] = 3'b000;
    s_ack    = 1'b0;
    @(negedge clk);
    chk("burst_end_grant", 64'(grant_o), 64'h2);
    chk("burst_end_ack", 64'(wbm_ack_o), 64'h0);
    step();
    @(negedge clk);
    chk("burst_gap", 64'(grant_o), 64'h0);
    step();
    @(negedge clk);
    chk("burst_next_grant", 64'(grant_o), 64'h1);
    chk("burst_next_cyc", 64'(wbs_cyc_o), 64'h1);
    step();
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    step();
    @(negedge clk);
    chk("burst_release", 64'(grant_o), 64'h0);

    // Timeout: slave never answers master 0; err on the 8th waiting cycle.
    step();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      chk($sformatf("to%0d_err", i), 64'(wbm_err_o), (i == 7) ? 64'h1 : 64'h0);
      chk($sformatf("to%0d_pulse", i), 64'(timeout_o), (i == 7) ? 64'h1 : 64'h0);
      chk($sformatf("to%0d_wbs_cyc", i), 64'(wbs_cyc_o), 64'h1);
    end
    step();
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    s_ack    = 1'b1;
    @(negedge clk);
    chk("abort_wbs_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("abort_wbs_stb", 64'(wbs_stb_o), 64'h0);
    chk("abort_pulse", 64'(timeout_o), 64'h0);
    chk("abort_err", 64'(wbm_err_o), 64'h0);
    chk("abort_ack", 64'(wbm_ack_o), 64'h0);
    chk("abort_grant", 64'(grant_o), 64'h1);
    step();
    s_ack    = 1'b0;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    @(negedge clk);
    chk("abort_hold", 64'(grant_o), 64'h1);
    step();
    @(negedge clk);
    chk("abort_idle", 64'(grant_o), 64'h0);
    step();
    @(negedge clk);
    chk("abort_next", 64'(grant_o), 64'h2);
    step();
    m_cyc[1] = 1'b0;
    m_stb[1] = 1'b0;
    step();
    @(negedge clk);
    chk("abort_done", 64'(grant_o), 64'h0);

    // Race: ack on the 8th waiting cycle beats the watchdog.
    step();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      s_ack = (i == 7);
      @(negedge clk);
      chk($sformatf("race%0d_err", i), 64'(wbm_err_o), 64'h0);
      chk($sformatf("race%0d_pulse", i), 64'(timeout_o), 64'h0);
      chk($sformatf("race%0d_ack", i), 64'(wbm_ack_o), (i == 7) ? 64'h1 : 64'h0);
    end
    step();
    s_ack    = 1'b0;
    m_stb[0] = 1'b0;
    @(negedge clk);
    chk("race_still_busy", 64'(wbs_cyc_o), 64'h1);
    chk("race_post_pulse", 64'(timeout_o), 64'h0);
    chk("race_post_grant", 64'(grant_o), 64'h1);
    step();
    m_cyc[0] = 1'b0;
    step();
    @(negedge clk);
    chk("race_idle", 64'(grant_o), 64'h0);

    // Asynchronous reset mid-transfer drops outputs at once.
    step();
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    step();
    @(negedge clk);
    chk("mid_grant", 64'(grant_o), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 64'(grant_o), 64'h0);
    chk("mid_rst_cyc", 64'(wbs_cyc_o), 64'h0);
    chk("mid_rst_stb", 64'(wbs_stb_o), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone B3 arbiter that shares one slave port (main RAM) between NUM_MASTERS packed master ports. These are the per-core instruction and data buses of the multi-core mor1kx system.
- A grant is held for the whole `cyc` of the winning master, so classic and incrementing bursts (`cti`/`bte`) pass through unbroken.
- A per-access watchdog terminates hung cycles with an error.
- The block sits between the core bus vectors and `wb_ram`.

## Interface
Parameters:
- NUM_MASTERS, 2: number of master ports (≥2).
- AW, 32: address width.
- DW, 32: data width; sel width is DW/8.
- TIMEOUT, 255: cycles `stb` may wait for ack/err/rty before abort. Range 1..65535.

Ports (master vectors are packed, master k occupies slice [W*(k+1)-1 : W*k]):
- wb_clk_i  in  1  clock; all state on rising edge.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- wbm_adr_i  in  AW*NUM_MASTERS  master addresses.
- wbm_dat_i  in  DW*NUM_MASTERS  master write data.
- wbm_sel_i  in  (DW/8)*NUM_MASTERS  byte selects.
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS each  write enable, cycle, strobe.
- wbm_cti_i  in  3*NUM_MASTERS  cycle type.
- wbm_bte_i  in  2*NUM_MASTERS  burst type.
- wbm_dat_o  out  DW*NUM_MASTERS  read data.
- wbm_ack_o, wbm_err_o, wbm_rty_o  out  NUM_MASTERS each  responses.
- wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave request.
- wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i  in  DW/1/1/1  slave response.
- grant_o  out  NUM_MASTERS  one-hot current grant, zero when idle.
- timeout_o  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states:
  - IDLE: no grant.
  - BUSY: grant held, requests forwarded.
  - ABORT: the granted cycle timed out; waiting for the master to drop `cyc`.
- IDLE: if any wbm_cyc_i[k] is high, pick the winner by round-robin.
  - The search starts at `last+1` and wraps modulo NUM_MASTERS.
  - Register the one-hot grant and `last` = winner; go to BUSY.
  - If no `cyc` is high, stay in IDLE.
- BUSY:
  - Slave request outputs are a mux of the granted master's request signals.
  - Response routing:
    - wbm_dat_o slice of the granted master = wbs_dat_i; all other slices are 0.
    - ack/err/rty are routed only to the granted bit; all others are 0.
  - When the granted master's cyc is low: clear the grant and go to IDLE. There is always one IDLE cycle between grants.
- Watchdog: a 16-bit counter.
  - Clears when the FSM is not in BUSY, when granted stb is low, or when any of ack/err/rty is high.
  - Otherwise it increments.
  - When it reaches TIMEOUT with no response:
    - that same cycle, assert wbm_err_o for the granted master and timeout_o;
    - go to ABORT.
- ABORT:
  - wbs_cyc_o = wbs_stb_o = 0; no responses are forwarded.
  - The grant stays held.
  - When the granted cyc falls: go to IDLE and clear the grant.
- Requests from non-granted masters are never forwarded. They receive no response until they win a grant.
- A master deasserting cyc before it is granted is simply skipped; no request is latched.

## Timing
- Reset values:
  - state IDLE, grant_o 0, `last` = NUM_MASTERS-1 (master 0 first after reset), counter 0.
  - All wbs_* outputs 0 while not in BUSY; timeout_o 0.
  - All wbm_*_o 0.
- Reset asserted mid-transfer: all outputs drop immediately, asynchronously.
- Arbitration latency: cyc sampled high in IDLE at edge N gives grant_o and wbs_cyc_o high after edge N.
- Response path: slave-to-master responses are combinational; add no extra latency. Burst throughput is one beat per slave ack.
- Simultaneous requests: resolved by round-robin only. With all masters requesting continuously, each master is granted once every NUM_MASTERS grants.
- Release: cyc low sampled in BUSY at edge M means IDLE after M. The earliest next grant is after M+1.
- Watchdog boundary: with stb waiting, err pulses exactly TIMEOUT cycles after stb is first seen in BUSY with no response.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins. In that case err and timeout_o are not asserted.
- timeout_o is exactly one cycle wide.

## Test plan
- Reset: hold wb_rst_ni=0 with all cyc high.
  - Expect grant_o=0 and wbs_cyc_o=0.
  - Release reset → grant_o=01 one cycle later (NUM_MASTERS=2).
- Round-robin: masters 0 and 1 each issue repeated single reads with cyc held between gaps.
  - Expect grants alternating 01,10,01,10.
  - Expect one IDLE cycle between each pair of grants.
- Burst hold: master 1 does a 4-beat incrementing burst (cti 010…111) while master 0 requests.
  - Expect master 1 to receive 4 acks uninterrupted, and master 0 to be granted only after master 1 drops cyc.
- Isolation: master 0 granted, and the slave returns dat=32'hDEADBEEF with ack.
  - Expect wbm_dat_o slice 0 = DEADBEEF, slice 1 = 0, and ack only on bit 0.
- Timeout: TIMEOUT=8, slave never acks.
  - Expect wbm_err_o[0] and timeout_o high exactly 8 cycles after stb, then wbs_cyc_o=0.
  - When the master drops cyc → IDLE, and the next requester is granted.
- Race: TIMEOUT=8, and the ack arrives on the 8th waiting cycle.
  - Expect ack delivered, no err, and no timeout_o.
